// File: rtl/pgen_multi.sv
// Multi-channel table-driven pattern generator: rows of CHANNELS x WIDTH values
// are loaded word-by-word, then emitted one row per trig rising edge while armed.
module pgen_multi #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      trig_i,
  input  logic                      table_reset_i,
  input  logic                      table_wstb_i,
  input  logic [WIDTH-1:0]          table_data_i,
  input  logic [31:0]               repeats_i,
  output logic [CHANNELS*WIDTH-1:0] out_o,
  output logic                      out_valid_o,
  output logic                      active_o,
  output logic [1:0]                state_o,
  output logic [$clog2(DEPTH):0]    length_o,
  output logic                      overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned RW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_DONE    = 2'd2,
    S_ERROR   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          enable_q, trig_q;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   rep_cnt_q, rep_cnt_d;
  logic [31:0]   repeats_q, repeats_d;
  logic [CW-1:0] chan_cnt_q, chan_cnt_d;
  logic [LW-1:0] length_q, length_d;
  logic          overflow_q, overflow_d;
  logic [RW-1:0] row_q, row_d;
  logic          mem_we;

  logic          v1_q, v2_q;
  logic [AW-1:0] ra_q;
  logic [RW-1:0] rd_data_q;
  logic [RW-1:0] out_q;
  logic          out_valid_q;

  logic          en_rise, en_fall, trig_rise;
  logic          issue, abort, last_row, wr_ok;

  logic [RW-1:0] mem [DEPTH];

  assign en_rise   = enable_i & ~enable_q;
  assign en_fall   = ~enable_i & enable_q;
  assign trig_rise = trig_i & ~trig_q;
  assign last_row  = (({1'b0, rd_ptr_q} + LW'(1)) == length_q);

  // Edge-detect history is kept through reset so a level held across reset
  // is not mistaken for a fresh edge.
  always_ff @(posedge clk_i) begin
    enable_q <= enable_i;
    trig_q   <= trig_i;
  end

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rep_cnt_d = rep_cnt_q;
    repeats_d = repeats_q;
    issue     = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      S_RUNNING: begin
        if (en_fall) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (trig_rise) begin
          issue = 1'b1;
          if (last_row) begin
            rd_ptr_d  = '0;
            rep_cnt_d = rep_cnt_q + 32'd1;
            if ((repeats_q != '0) && ((rep_cnt_q + 32'd1) == repeats_q)) begin
              state_d = S_DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: begin
        if (en_rise) begin
          if (length_q != '0) begin
            state_d   = S_RUNNING;
            rd_ptr_d  = '0;
            rep_cnt_d = '0;
            repeats_d = repeats_i;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
    endcase
  end

  always_comb begin
    chan_cnt_d = chan_cnt_q;
    length_d   = length_q;
    overflow_d = overflow_q;
    row_d      = row_q;
    mem_we     = 1'b0;
    wr_ok      = table_wstb_i && (length_q != LW'(DEPTH)) && (state_q != S_RUNNING);
    if (table_reset_i) begin
      chan_cnt_d = '0;
      length_d   = '0;
      overflow_d = 1'b0;
    end else if (table_wstb_i && !wr_ok) begin
      overflow_d = 1'b1;
    end else if (wr_ok) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (chan_cnt_q == CW'(c)) row_d[c*WIDTH +: WIDTH] = table_data_i;
      end
      if (chan_cnt_q == CW'(CHANNELS - 1)) begin
        chan_cnt_d = '0;
        length_d   = length_q + LW'(1);
        mem_we     = 1'b1;
      end else begin
        chan_cnt_d = chan_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[length_q[AW-1:0]] <= row_d;
    rd_data_q <= mem[ra_q];
  end

  // Pipeline: address at the trig edge, RAM data one edge later, output the
  // edge after; an abort clears whatever is still in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      rep_cnt_q   <= '0;
      repeats_q   <= '0;
      chan_cnt_q  <= '0;
      length_q    <= '0;
      overflow_q  <= 1'b0;
      row_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      ra_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rep_cnt_q   <= rep_cnt_d;
      repeats_q   <= repeats_d;
      chan_cnt_q  <= chan_cnt_d;
      length_q    <= length_d;
      overflow_q  <= overflow_d;
      row_q       <= row_d;
      v1_q        <= issue;
      if (issue) ra_q <= rd_ptr_q;
      v2_q        <= v1_q & ~abort;
      out_valid_q <= v2_q & ~abort;
      if (v2_q && !abort) out_q <= rd_data_q;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign active_o    = (state_q == S_RUNNING);
  assign state_o     = state_q;
  assign length_o    = length_q;
  assign overflow_o  = overflow_q;

endmodule

// File: doc/pgen_multi.md
# pgen_multi

Multi-channel table-driven pattern generator for the PandA position bus: a successor to the single-channel PGEN block, generalised to CHANNELS parallel outputs per table row, parametric depth and width, a finite or infinite repeat count, and explicit status and error reporting. The table is loaded word-by-word from the register/DMA side. Once armed by a rising edge on enable_i, each rising edge on trig_i emits one row. Its outputs feed the position bus and its active flag feeds the bit bus, so PCAP sequences can be stimulated in simulation and on hardware.

## Interface
- CHANNELS, 2: values per table row (1..8)
- WIDTH, 32: bits per channel value
- DEPTH, 1024: table rows, power of two
- clk_i  in  1  system clock (FCLK domain)
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  arm level; rising edge starts, falling edge aborts
- trig_i  in  1  advance; rising edge emits next row
- table_reset_i  in  1  pulse: clear write pointer, length and error flags
- table_wstb_i  in  1  pulse: write table_data_i
- table_data_i  in  WIDTH  table word, channel-major within a row
- repeats_i  in  32  table passes before done; 0 = infinite
- out_o  out  CHANNELS*WIDTH  current row; channel 0 in LSBs
- out_valid_o  out  1  one-cycle pulse per emitted row
- active_o  out  1  high while RUNNING
- state_o  out  2  0 IDLE, 1 RUNNING, 2 DONE, 3 ERROR
- length_o  out  log2(DEPTH)+1  complete rows loaded
- overflow_o  out  1  sticky: write while full or while active

## Operation
- Loading:
  - Each accepted wstb writes column chan_cnt of row length_o, then increments chan_cnt.
  - When chan_cnt wraps from CHANNELS-1 to 0, length_o increments. A partially written row is not counted.
  - A wstb is ignored and overflow_o is set when length_o == DEPTH or when state is RUNNING.
  - table_reset_i clears chan_cnt, length_o and overflow_o. Table RAM contents are untouched.
- FSM:
  - IDLE/DONE/ERROR -> RUNNING on an enable_i rising edge with length_o > 0. On entry: rd_ptr = 0, rep_cnt = 0.
  - IDLE/DONE -> ERROR on an enable_i rising edge with length_o == 0.
  - RUNNING -> IDLE on an enable_i falling edge (abort).
  - RUNNING -> DONE after the last row of pass repeats_i has been emitted (repeats_i != 0).
  - ERROR is left only by the next valid enable rising edge or by reset.
- Emission (RUNNING only): a trig_i rising edge reads row rd_ptr.
  - rd_ptr == length_o-1: rd_ptr wraps to 0 and rep_cnt increments.
  - If repeats_i != 0 and rep_cnt+1 == repeats_i, the FSM goes to DONE the same edge the final read issues. That final row is still emitted.
  - repeats_i == 0 means the table repeats indefinitely; rep_cnt wraps modulo 2^32.
- out_o holds its last value in every state. It changes only when an emission occurs or on reset.
- Simultaneous events:
  - enable rising and trig rising on the same edge: arm only, trig ignored.
  - enable falling and trig rising on the same edge: abort wins, no emission.
  - table_reset_i and table_wstb_i on the same edge: reset wins, the write is dropped.
- repeats_i is sampled at the enable rising edge; later changes are ignored until re-arm.

## Timing
- Edge detection compares the input with its value registered on the previous edge.
- Trig rising edge sampled at edge N:
  - RAM read issues at edge N.
  - out_o and out_valid_o update at edge N+2: fixed 2-cycle latency, no back-pressure.
- Throughput: one row per trig rising edge. The fastest trig is one-high/one-low, i.e. one row every 2 cycles.
- active_o / state_o change at the edge where the triggering condition is sampled (1 cycle after the input changes).
- An abort edge cancels an emission still in the pipeline: out_valid_o stays low and out_o is not updated.
- reset_i at any point, including mid-pass, at the next edge:
  - out_o = 0, out_valid_o = 0, active_o = 0, state_o = IDLE.
  - length_o = 0, overflow_o = 0, all pointers 0.
- Required resources: one simple dual-port RAM of DEPTH x CHANNELS*WIDTH with registered read. The write side uses per-column byte-enables or a row assembly register.

## Test plan
- Load, CHANNELS=2: 6 words 1..6 -> length_o=3. Arm with repeats_i=1, 3 trigs -> out_o = {2,1}, {4,3}, {6,5}, each at trig+2. Then state DONE, active_o=0.
- repeats_i=2, length 3, 7 trigs -> 6 valid pulses in row order 0,1,2,0,1,2. 7th trig gives no pulse, state DONE. With repeats_i=0, 100 trigs -> 100 pulses, rows cycling modulo 3.
- Arm with table empty -> state_o=3, active_o=0, no pulses. Then load 2 words and re-arm -> RUNNING.
- Fill DEPTH rows, then 1 more wstb -> length_o=DEPTH, overflow_o=1. wstb while RUNNING -> overflow_o=1, table unchanged. table_reset_i -> length_o=0, overflow_o=0.
- Same-edge enable rise+trig -> no pulse. Trig, then enable fall one cycle later -> no pulse, IDLE. Enable fall+trig same edge -> no pulse.
- reset_i mid-pass at row 1 -> all outputs 0 at the next edge. Re-arm after reload -> emission restarts at row 0.
